// File: rtl/prbs_pkg.sv
// Shared types and LFSR tap selection for the PRBS pattern source and future checkers.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int TAP_ORDER7  = 6;   // x^7 + x^6 + 1
  localparam int TAP_ORDER31 = 28;  // x^31 + x^28 + 1

  function automatic bit prbs_order_ok(input int order);
    return (order == 7) || (order == 31);
  endfunction

  function automatic int prbs_tap(input int order);
    return (order == 7) ? TAP_ORDER7 : TAP_ORDER31;
  endfunction

endpackage

// File: rtl/prbs_word_step.sv
// Combinational advance of a Fibonacci LFSR by WIDTH serial steps; first bit lands in the word MSB.
module prbs_word_step
  import prbs_pkg::*;
#(
  parameter int ORDER = 31,
  parameter int WIDTH = 32
) (
  input  logic [ORDER-1:0] state_cur,
  output logic [ORDER-1:0] state_next,
  output logic [WIDTH-1:0] word
);

  localparam int TAP = prbs_tap(ORDER);

  always_comb begin
    logic [ORDER-1:0] s;
    logic             nb;
    s    = state_cur;
    nb   = 1'b0;
    word = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      nb      = s[ORDER-1] ^ s[TAP-1];
      s       = {s[ORDER-2:0], nb};
      word[i] = nb;
    end
    state_next = s;
  end

endmodule

// File: rtl/prbs_stream_gen.sv
// Word-parallel PRBS source with an AXI-Stream master port, burst control and bit-0 error injection.
//   state | meaning
//   IDLE  | no stream, TVALID low
//   RUN   | output register reloads on every accept
//   DRAIN | last word presented, waiting for its accept
module prbs_stream_gen
  import prbs_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int PRBS_ORDER  = 31
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PRBS_ORDER-1:0]  seed,
  input  logic [31:0]            burst_len,
  input  logic                   inject_err,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            word_count
);

  if (!prbs_order_ok(PRBS_ORDER)) begin : g_bad_order
    $error("prbs_stream_gen: PRBS_ORDER must be 7 or 31");
  end
  if (TDATA_WIDTH < 8) begin : g_bad_width
    $error("prbs_stream_gen: TDATA_WIDTH must be at least 8");
  end

  state_t                  state_q, state_d;
  logic [PRBS_ORDER-1:0]   lfsr_q, lfsr_d;
  logic [TDATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic [31:0]             remain_q, remain_d;
  logic                    endless_q, endless_d;
  logic                    burst_exit_q, burst_exit_d;
  logic                    pending_q, pending_d;
  logic                    done_q, done_d;
  logic [31:0]             word_count_q, word_count_d;

  logic [PRBS_ORDER-1:0]   seed_eff, step_in, step_next;
  logic [TDATA_WIDTH-1:0]  step_word;
  logic                    accept, inj;

  assign seed_eff = (seed == '0) ? '1 : seed;
  assign step_in  = (state_q == IDLE) ? seed_eff : lfsr_q;
  assign accept   = tvalid_q & M_AXIS_TREADY;
  assign inj      = inject_err | pending_q;

  prbs_word_step #(
    .ORDER (PRBS_ORDER),
    .WIDTH (TDATA_WIDTH)
  ) u_step (
    .state_cur  (step_in),
    .state_next (step_next),
    .word       (step_word)
  );

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    remain_d     = remain_q;
    endless_d    = endless_q;
    burst_exit_d = burst_exit_q;
    pending_d    = pending_q | inject_err;
    done_d       = 1'b0;
    word_count_d = word_count_q + {31'd0, accept};
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d      = RUN;
          lfsr_d       = step_next;
          tdata_d      = step_word ^ {{(TDATA_WIDTH-1){1'b0}}, inject_err};
          tvalid_d     = 1'b1;
          pending_d    = 1'b0;
          word_count_d = '0;
          endless_d    = (burst_len == 32'd0);
          remain_d     = burst_len - 32'd1;
          burst_exit_d = 1'b0;
          if (burst_len == 32'd1) begin
            state_d      = DRAIN;
            burst_exit_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          // A word accepted in the stop cycle leaves nothing to drain.
          if (!tvalid_q || accept) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (!tvalid_q || accept) begin
          lfsr_d    = step_next;
          tdata_d   = step_word ^ {{(TDATA_WIDTH-1){1'b0}}, inj};
          tvalid_d  = 1'b1;
          pending_d = 1'b0;
          remain_d  = remain_q - 32'd1;
          if (!endless_q && remain_q == 32'd1) begin
            state_d      = DRAIN;
            burst_exit_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!tvalid_q || accept) begin
          state_d  = IDLE;
          tvalid_d = 1'b0;
          done_d   = burst_exit_q;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      lfsr_q       <= '1;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      remain_q     <= '0;
      endless_q    <= 1'b0;
      burst_exit_q <= 1'b0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      remain_q     <= remain_d;
      endless_q    <= endless_d;
      burst_exit_q <= burst_exit_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Self-checking bench for prbs_stream_gen (order 7, 8-bit words) against a bit-sequence PRBS model.
module tb_prbs_stream_gen;

  logic        clk;
  logic        areset;
  logic        start;
  logic        stop;
  logic [6:0]  seed;
  logic [31:0] burst_len;
  logic        inject_err;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic        done;
  logic [31:0] word_count;

  int n_cmp;
  int n_bad;

  prbs_stream_gen #(
    .TDATA_WIDTH (8),
    .PRBS_ORDER  (7)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .start         (start),
    .stop          (stop),
    .seed          (seed),
    .burst_len     (burst_len),
    .inject_err    (inject_err),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Model: b[n] = b[n-7] ^ b[n-6]; the seed supplies b[-7..-1] (seed MSB is b[-7]).
  bit mbits[$];

  task automatic model_build(input logic [6:0] sd, input int nwords);
    logic [6:0] eff;
    eff = (sd == 7'd0) ? 7'h7F : sd;
    mbits.delete();
    for (int k = 6; k >= 0; k--) mbits.push_back(eff[k]);
    for (int n = 0; n < nwords * 8; n++) mbits.push_back(mbits[n] ^ mbits[n+1]);
  endtask

  function automatic logic [7:0] model_word(input int w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = mbits[7 + 8*w + i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_start(input logic [6:0] sd, input logic [31:0] blen);
    seed      = sd;
    burst_len = blen;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Finite burst with random back-pressure; checks data, hold-during-stall and completion.
  task automatic run_burst(input logic [6:0] sd, input int blen, input int pct,
                           input logic [7:0] exp_first);
    int         acc;
    int         dones;
    int         cyc;
    bit         stall;
    bit         first;
    logic [7:0] prev;
    acc   = 0;
    dones = 0;
    stall = 0;
    first = 1;
    prev  = '0;
    model_build(sd, blen + 4);
    tready = 1'b0;
    do_start(sd, blen);
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (done) dones++;
      if (stall) begin
        chk("hold_valid", {31'd0, tvalid}, 32'd1);
        chk("hold_data", {24'd0, tdata}, {24'd0, prev});
      end
      if (!busy) break;
      if (tvalid && first) begin
        chk("first_word", {24'd0, tdata}, {24'd0, exp_first});
        first = 0;
      end
      tready = ($urandom_range(99) < pct);
      if (tvalid && tready) begin
        chk("burst_word", {24'd0, tdata}, {24'd0, model_word(acc)});
        acc++;
      end
      stall = tvalid && !tready;
      prev  = tdata;
      @(negedge clk);
    end
    if (cyc >= 2000) chk("burst_timeout", 32'd0, 32'd1);
    tready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("burst_accepts", acc, blen);
    chk("burst_done_pulses", dones, 32'd1);
    chk("burst_busy_after", {31'd0, busy}, 32'd0);
    chk("burst_valid_after", {31'd0, tvalid}, 32'd0);
    chk("burst_word_count", word_count, blen);
  endtask

  typedef struct {
    logic [6:0] sd;
    int         blen;
    int         pct;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    areset     = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    seed       = '0;
    burst_len  = '0;
    inject_err = 1'b0;
    tready     = 1'b0;

    vecs[0] = '{sd: 7'h7F, blen: 5, pct: 50,  exp_first: 8'h02};
    vecs[1] = '{sd: 7'h00, blen: 5, pct: 60,  exp_first: 8'h02};
    vecs[2] = '{sd: 7'h01, blen: 3, pct: 100, exp_first: 8'h06};
    vecs[3] = '{sd: 7'h7F, blen: 1, pct: 40,  exp_first: 8'h02};
    vecs[4] = '{sd: 7'h01, blen: 8, pct: 30,  exp_first: 8'h06};
    vecs[5] = '{sd: 7'h00, blen: 2, pct: 20,  exp_first: 8'h02};

    repeat (3) @(negedge clk);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, tdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_word_count", word_count, 32'd0);
    areset = 1'b0;
    @(negedge clk);

    // Endless run at full rate: 127-word period, no bubbles, stop with accept ends at once.
    model_build(7'h7F, 300);
    tready = 1'b1;
    do_start(7'h7F, 32'd0);
    for (int i = 0; i < 260; i++) begin
      chk("t1_valid", {31'd0, tvalid}, 32'd1);
      chk("t1_word", {24'd0, tdata}, {24'd0, model_word(i)});
      if (i == 0 || i == 127 || i == 254) chk("t1_period", {24'd0, tdata}, 32'h02);
      @(negedge clk);
    end
    do_stop();
    chk("t1_stop_valid", {31'd0, tvalid}, 32'd0);
    chk("t1_stop_busy", {31'd0, busy}, 32'd0);
    chk("t1_word_count", word_count, 32'd261);
    @(negedge clk);
    chk("t1_no_done", {31'd0, done}, 32'd0);

    for (int v = 0; v < 6; v++)
      run_burst(vecs[v].sd, vecs[v].blen, vecs[v].pct, vecs[v].exp_first);

    // Single-word error injection while word 2 is presented corrupts only word 3, bit 0.
    model_build(7'h01, 20);
    tready = 1'b1;
    do_start(7'h01, 32'd0);
    for (int i = 0; i < 12; i++) begin
      inject_err = (i == 2);
      chk("inj_word", {24'd0, tdata}, {24'd0, model_word(i) ^ ((i == 3) ? 8'h01 : 8'h00)});
      @(negedge clk);
    end
    inject_err = 1'b0;
    do_stop();
    chk("inj_stopped", {31'd0, busy}, 32'd0);

    // Stop under back-pressure: presented word held until accepted, no done.
    model_build(7'h7F, 10);
    tready = 1'b1;
    do_start(7'h7F, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_word", {24'd0, tdata}, {24'd0, model_word(i)});
      @(negedge clk);
    end
    tready = 1'b0;
    do_stop();
    for (int k = 0; k < 4; k++) begin
      chk("t5_hold_valid", {31'd0, tvalid}, 32'd1);
      chk("t5_hold_data", {24'd0, tdata}, {24'd0, model_word(3)});
      chk("t5_hold_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    tready = 1'b1;
    @(negedge clk);
    chk("t5_end_valid", {31'd0, tvalid}, 32'd0);
    chk("t5_end_busy", {31'd0, busy}, 32'd0);
    chk("t5_word_count", word_count, 32'd4);
    chk("t5_no_done_a", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("t5_no_done_b", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-burst takes effect before the next clock edge.
    do_start(7'h7F, 32'd20);
    repeat (4) @(negedge clk);
    #2 areset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, tvalid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_count", word_count, 32'd0);
    @(negedge clk);
    areset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_valid", {31'd0, tvalid}, 32'd0);
    end

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("t6_ss_busy", {31'd0, busy}, 32'd0);
    chk("t6_ss_valid", {31'd0, tvalid}, 32'd0);
    @(negedge clk);
    chk("t6_ss_busy2", {31'd0, busy}, 32'd0);

    // word_count wraps from 0xFFFFFFFF to 0.
    tready = 1'b1;
    do_start(7'h7F, 32'd0);
    force dut.word_count_q = 32'hFFFF_FFFE;
    #1 release dut.word_count_q;
    @(negedge clk);
    chk("wrap_max", word_count, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap_zero", word_count, 32'd0);
    @(negedge clk);
    chk("wrap_one", word_count, 32'd1);
    do_stop();
    tready = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
